// File: rtl/toplayici_hakem_pkg.sv
// toplayici_hakem_pkg: shared adder defaults, requester IDs and the in-flight tag type
package toplayici_hakem_pkg;
  localparam int W_DEF = 32;
  localparam int LAT_DEF = 2;
  localparam int DEPTH_DEF = 4;
  localparam logic ID_ALU = 1'b0;
  localparam logic ID_AGU = 1'b1;
  typedef struct packed {
    logic v;
    logic id;
  } tag_t;
endpackage

// File: rtl/sonuc_fifo.sv
// sonuc_fifo: first-word-fall-through result FIFO, modulo-DEPTH pointers
module sonuc_fifo #(
  parameter int W = 34,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_wr, w_rd;
  assign w_wr = i_wr & ~o_full;
  assign w_rd = i_rd & ~o_empty;
  assign o_empty = r_cnt == '0;
  assign o_full = r_cnt == CW'(DEPTH);
  // head reads as zero while empty so the result port shows reset values
  assign o_rdata = o_empty ? '0 : r_mem[r_rp];
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_wp] <= i_wdata;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp == AW'(DEPTH - 1) ? '0 : r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp == AW'(DEPTH - 1) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
    end
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_wr && o_full));
endmodule

// File: rtl/toplayici_hakem.sv
// toplayici_hakem: round-robin, credit-limited arbiter for a shared pipelined adder
module toplayici_hakem
  import toplayici_hakem_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int LAT = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req0_valid,
  output logic         o_req0_ready,
  input  logic [W-1:0] i_req0_a,
  input  logic [W-1:0] i_req0_b,
  input  logic         i_req0_sub,
  input  logic         i_req1_valid,
  output logic         o_req1_ready,
  input  logic [W-1:0] i_req1_a,
  input  logic [W-1:0] i_req1_b,
  input  logic         i_req1_sub,
  output logic         o_add_valid,
  output logic [W-1:0] o_add_a,
  output logic [W-1:0] o_add_b,
  output logic         o_add_cin,
  input  logic [W-1:0] i_add_sum,
  input  logic         i_add_cout,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [W-1:0] o_res_sum,
  output logic         o_res_cout,
  output logic         o_res_id,
  output logic         o_busy
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] r_cnt;
  logic r_ptr, r_add_id;
  tag_t r_tag [LAT];
  logic w_credit_ok, w_gnt0, w_gnt1, w_acc, w_deq, w_sel_sub, w_empty, w_full;
  logic [W-1:0] w_sel_a, w_sel_b;
  assign w_credit_ok = r_cnt < CW'(DEPTH);
  assign w_gnt0 = i_req0_valid & (~i_req1_valid | ~r_ptr);
  assign w_gnt1 = i_req1_valid & (~i_req0_valid | r_ptr);
  assign o_req0_ready = w_credit_ok & w_gnt0;
  assign o_req1_ready = w_credit_ok & w_gnt1;
  assign w_acc = o_req0_ready | o_req1_ready;
  assign w_sel_a = o_req1_ready ? i_req1_a : i_req0_a;
  assign w_sel_b = o_req1_ready ? i_req1_b : i_req0_b;
  assign w_sel_sub = o_req1_ready ? i_req1_sub : i_req0_sub;
  assign w_deq = o_res_valid & i_res_ready;
  assign o_res_valid = ~w_empty;
  assign o_busy = r_cnt != '0;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_add_valid <= 1'b0;
      o_add_a <= '0;
      o_add_b <= '0;
      o_add_cin <= 1'b0;
      r_add_id <= ID_ALU;
      r_ptr <= 1'b0;
      r_cnt <= '0;
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else begin
      o_add_valid <= w_acc;
      if (w_acc) begin
        o_add_a <= w_sel_a;
        o_add_b <= w_sel_sub ? ~w_sel_b : w_sel_b;
        o_add_cin <= w_sel_sub;
        r_add_id <= o_req1_ready ? ID_AGU : ID_ALU;
        r_ptr <= o_req0_ready;
      end
      // tag rides alongside the adder so it lines up with i_add_sum
      r_tag[0] <= '{v: o_add_valid, id: r_add_id};
      for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
      r_cnt <= r_cnt + CW'(w_acc) - CW'(w_deq);
    end
  sonuc_fifo #(.W(W + 2), .DEPTH(DEPTH)) u_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_wr   (r_tag[LAT-1].v),
    .i_wdata({i_add_sum, i_add_cout, r_tag[LAT-1].id}),
    .i_rd   (w_deq),
    .o_rdata({o_res_sum, o_res_cout, o_res_id}),
    .o_empty(w_empty),
    .o_full (w_full)
  );
endmodule

// File: tb/tb_toplayici_hakem.sv
// tb_toplayici_hakem: random and directed stimulus against an accept-order result model
module tb_toplayici_hakem;
  localparam int W = 32;
  localparam int LAT = 2;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic v0 = 0, v1 = 0, s0 = 0, s1 = 0, rr = 0;
  logic [W-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic rdy0, rdy1, add_valid, add_cin, add_cout = 0, res_valid, res_cout, res_id, busy;
  logic [W-1:0] add_a, add_b, add_sum = 0, res_sum;

  toplayici_hakem #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_sub(s0),
    .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_sub(s1),
    .o_add_valid(add_valid), .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
    .i_add_sum(add_sum), .i_add_cout(add_cout),
    .o_res_valid(res_valid), .i_res_ready(rr), .o_res_sum(res_sum), .o_res_cout(res_cout),
    .o_res_id(res_id), .o_busy(busy)
  );

  typedef struct {logic [W-1:0] s; logic c; logic id; int cyc;} res_t;
  typedef struct {logic v; logic [W-1:0] a; logic [W-1:0] b; logic cin;} add_t;
  res_t q[$];
  add_t hist[$];
  int checks = 0, failures = 0, cyc = 0;
  logic last_win = 1'b1, pend = 1'b0, pcin;
  logic [W-1:0] pa, pb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, b, input logic sub, id, input int c);
    res_t r;
    logic [W:0] wide;
    wide = {1'b0, a} + {1'b0, b};
    r.s = sub ? a - b : a + b;
    r.c = sub ? (a >= b) : wide[W];
    r.id = id;
    r.cyc = c;
    return r;
  endfunction

  task automatic set_req(input logic iv0, input logic [W-1:0] ia0, ib0, input logic is0,
                         input logic iv1, input logic [W-1:0] ia1, ib1, input logic is1, input logic irr);
    v0 = iv0; a0 = ia0; b0 = ib0; s0 = is0;
    v1 = iv1; a1 = ia1; b1 = ib1; s1 = is1;
    rr = irr;
  endtask

  task automatic step();
    logic ok, g0, g1;
    logic [W:0] wide;
    res_t h;
    add_t e;
    @(negedge clk);
    ok = q.size() < DEPTH;
    g0 = v0 && (!v1 || last_win);
    g1 = v1 && (!v0 || !last_win);
    chk("ready0", rdy0, ok && g0);
    chk("ready1", rdy1, ok && g1);
    chk("busy", busy, q.size() != 0);
    chk("add_valid", add_valid, pend);
    if (pend) begin
      chk("add_a", add_a, pa);
      chk("add_b", add_b, pb);
      chk("add_cin", add_cin, pcin);
    end
    if (q.size() == 0) chk("res_extra", res_valid, 0);
    else begin
      if (res_valid) chk("res_early", cyc >= q[0].cyc + LAT + 2, 1);
      if (cyc >= q[0].cyc + LAT + 2) chk("res_late", res_valid, 1);
      if (res_valid && rr) begin
        h = q.pop_front();
        chk("res", {res_sum, res_cout, res_id}, {h.s, h.c, h.id});
      end
    end
    pend = 0;
    if (ok && (g0 || g1)) begin
      q.push_back(g1 ? model(a1, b1, s1, 1'b1, cyc) : model(a0, b0, s0, 1'b0, cyc));
      pend = 1;
      pa = g1 ? a1 : a0;
      pb = g1 ? (s1 ? ~b1 : b1) : (s0 ? ~b0 : b0);
      pcin = g1 ? s1 : s0;
      last_win = g1;
    end
    @(posedge clk);
    #1;
    cyc++;
    hist.push_back('{add_valid, add_a, add_b, add_cin});
    if (hist.size() > LAT) begin
      e = hist.pop_front();
      if (e.v) wide = {1'b0, e.a} + {1'b0, e.b} + (W+1)'(e.cin);
      else wide = (W+1)'($urandom);
      {add_cout, add_sum} = wide;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("rst_add_valid", add_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", {res_sum, res_cout, res_id}, 0);
    chk("rst_busy", busy, 0);
    q.delete();
    pend = 0;
    last_win = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic idle(input int n, input logic irr);
    set_req(0, 0, 0, 0, 0, 0, 0, 0, irr);
    repeat (n) step();
  endtask

  initial begin
    do_reset();
    set_req(1, 5, 3, 0, 0, 0, 0, 0, 1);
    step();
    idle(6, 1);
    set_req(0, 0, 0, 0, 1, 3, 5, 1, 1);
    step();
    idle(6, 1);
    for (int i = 0; i < 8; i++) begin
      set_req(1, $urandom, $urandom, 1'($urandom), 1, $urandom, $urandom, 1'($urandom), 1);
      step();
    end
    idle(8, 1);
    set_req(1, 7, 2, 0, 0, 0, 0, 0, 0);
    repeat (8) step();
    rr = 1;
    step();
    rr = 0;
    repeat (3) step();
    idle(10, 1);
    set_req(1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 1);
    step();
    idle(6, 1);
    set_req(1, 11, 4, 1, 0, 0, 0, 0, 0);
    repeat (3) step();
    do_reset();
    idle(1, 1);
    set_req(0, 0, 0, 0, 1, 9, 20, 1, 1);
    step();
    idle(6, 1);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      set_req(1'($urandom), $urandom, ($urandom % 3 == 0) ? $urandom % 8 : $urandom, 1'($urandom),
              1'($urandom), $urandom, $urandom, 1'($urandom), ($urandom % 4) != 0);
      step();
    end
    idle(12, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
